// File: rtl/tmc_reg_pkg.sv
// Shared constants for the multi-channel TMC register block:
// register map, STATUS bit positions and FSM state encoding.
package tmc_reg_pkg;

  localparam logic [7:0] ADDR_MOSI_HI   = 8'h00;
  localparam logic [7:0] ADDR_MOSI_LO   = 8'h01;
  localparam logic [7:0] ADDR_CMD       = 8'h02;
  localparam logic [7:0] ADDR_STATUS    = 8'h03;
  localparam logic [7:0] ADDR_IRQ_EN    = 8'h04;
  localparam logic [7:0] ADDR_MISO_BASE = 8'h10;

  localparam int ST_BUSY  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_FULL  = 2;
  localparam int ST_DONE  = 3;
  localparam int ST_OVF   = 4;
  localparam int ST_CHERR = 5;
  localparam int ST_TO    = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

endpackage

// File: rtl/tmc_cmd_fifo.sv
// Show-ahead command FIFO: rdata always presents the head entry.
// Ports: push/wdata, pop/rdata, full, empty, level; async active-low reset.
module tmc_cmd_fifo #(
  parameter  int W     = 42,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  // A pop frees a slot in the same cycle, so a push on full is accepted.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign rdata = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      wp    <= wp + AW'(do_push);
      rp    <= rp + AW'(do_pop);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/tmc_reg_mc.sv
// Multi-channel TMC SPI datagram queue: Avalon-MM slave, command FIFO, launch FSM,
// per-channel MISO latches, sticky flags + irq. Optional watchdog: TMC_TIMEOUT_EN.
module tmc_reg_mc
  import tmc_reg_pkg::*;
#(
  parameter  int CH_NUM     = 4,
  parameter  int DATA_W     = 40,
  parameter  int FIFO_DEPTH = 8,
  parameter  int TO_CYCLES  = 65535,
  localparam int CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_write_data,
  input  logic              avs_read,
  output logic [31:0]       avs_read_data,
  output logic              irq,
  output logic              tmc_start,
  output logic [CH_W-1:0]   tmc_ch,
  output logic [DATA_W-1:0] tmc_mosi_data,
  input  logic              tmc_done,
  input  logic [DATA_W-1:0] tmc_miso_data
);

  localparam int HI_W = DATA_W - 32;
  localparam int FW   = CH_W + DATA_W;
  localparam int LW   = $clog2(FIFO_DEPTH) + 1;

  state_t state;
  state_t state_nx;

  logic [HI_W-1:0]   stg_hi;
  logic [31:0]       stg_lo;
  logic [DATA_W-1:0] miso [CH_NUM];
  logic [6:3]        sticky;
  logic [6:3]        irq_en;
  logic [6:3]        st_set;
  logic [6:3]        st_clr;

  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic [FW-1:0] fifo_rd;

  logic       wr_cmd;
  logic       wr_stat;
  logic [3:0] cmd_ch;
  logic       ch_bad;
  logic       ovf_ev;
  logic       done_ev;
  logic       to_ev;
  logic       busy;

  logic [7:0]        miso_off;
  logic              miso_hit;
  logic [DATA_W-1:0] miso_sel;
  logic [31:0]       rd_mux;

  assign wr_cmd  = avs_write && (avs_address == ADDR_CMD);
  assign wr_stat = avs_write && (avs_address == ADDR_STATUS);
  assign cmd_ch  = avs_write_data[3:0];
  assign ch_bad  = (32'(cmd_ch) >= CH_NUM);

  assign busy    = (state != IDLE);
  assign pop     = (state == IDLE) && !empty;
  assign ovf_ev  = wr_cmd && full && !pop;
  assign push    = wr_cmd && !ch_bad && !ovf_ev;
  assign done_ev = (state == WAIT) && tmc_done;

  tmc_cmd_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({cmd_ch[CH_W-1:0], stg_hi, stg_lo}),
    .pop   (pop),
    .rdata (fifo_rd),
    .full  (full),
    .empty (empty),
    .level (level)
  );

`ifdef TMC_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt <= '0;
    else if (state != WAIT) to_cnt <= '0;
    else to_cnt <= to_cnt + TW'(1);
  end

  // A done arriving in the expiry cycle still counts as a completion.
  assign to_ev = (state == WAIT) && !tmc_done &&
                 (to_cnt == TW'(TO_CYCLES - 1));
`else
  logic unused_to;
  assign unused_to = (TO_CYCLES > 0);
  assign to_ev     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    tmc_start = 1'b0;
    case (state)
      IDLE:   if (pop) state_nx = LAUNCH;
      LAUNCH: begin
        tmc_start = 1'b1;
        state_nx  = WAIT;
      end
      WAIT:   if (done_ev || to_ev) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmc_ch        <= '0;
      tmc_mosi_data <= '0;
    end else if (pop) begin
      tmc_ch        <= fifo_rd[FW-1:DATA_W];
      tmc_mosi_data <= fifo_rd[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_hi <= '0;
      stg_lo <= '0;
      irq_en <= '0;
    end else if (avs_write) begin
      if (avs_address == ADDR_MOSI_HI) stg_hi <= avs_write_data[HI_W-1:0];
      if (avs_address == ADDR_MOSI_LO) stg_lo <= avs_write_data;
      if (avs_address == ADDR_IRQ_EN)  irq_en <= avs_write_data[6:3];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_NUM; i++) miso[i] <= '0;
    end else if (done_ev) begin
      miso[tmc_ch] <= tmc_miso_data;
    end
  end

  assign st_set = {to_ev, wr_cmd && ch_bad, ovf_ev, done_ev};
  assign st_clr = wr_stat ? avs_write_data[6:3] : 4'b0;

  // Set terms are OR-ed after the clear, so a set beats a same-cycle W1C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= '0;
      irq    <= 1'b0;
    end else begin
      sticky <= (sticky & ~st_clr) | st_set;
      irq    <= |(sticky & irq_en);
    end
  end

  assign miso_off = avs_address - ADDR_MISO_BASE;
  assign miso_hit = (avs_address >= ADDR_MISO_BASE) &&
                    (miso_off[7:1] < 7'(CH_NUM));
  assign miso_sel = miso[miso_off[CH_W:1]];

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      (avs_address == ADDR_MOSI_HI): rd_mux = 32'(stg_hi);
      (avs_address == ADDR_MOSI_LO): rd_mux = stg_lo;
      (avs_address == ADDR_STATUS):
        rd_mux = {16'b0, 8'(level), 1'b0, sticky, full, empty, busy};
      (avs_address == ADDR_IRQ_EN):  rd_mux = {25'b0, irq_en, 3'b0};
      (miso_hit && !miso_off[0]):    rd_mux = 32'(miso_sel[DATA_W-1:32]);
      (miso_hit && miso_off[0]):     rd_mux = miso_sel[31:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) avs_read_data <= '0;
    else avs_read_data <= avs_read ? rd_mux : 32'b0;
  end

endmodule

// File: tb/tb_tmc_reg_mc.sv
// Self-checking bench for tmc_reg_mc: SPI engine model with start scoreboard,
// table-driven datagram vectors and hand-written overflow/error/reset sequences.
`timescale 1ns/1ps
module tb_tmc_reg_mc;
  import tmc_reg_pkg::*;

  localparam int CH_NUM = 4;
  localparam int DW     = 40;
  localparam int DEPTH  = 8;
`ifdef TMC_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 65535;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    avs_address = '0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_write_data = '0;
  logic          avs_read = 1'b0;
  logic [31:0]   avs_read_data;
  logic          irq;
  logic          tmc_start;
  logic [1:0]    tmc_ch;
  logic [DW-1:0] tmc_mosi_data;
  logic          tmc_done = 1'b0;
  logic [DW-1:0] tmc_miso_data = '0;

  always #5 clk = ~clk;

  tmc_reg_mc #(
    .CH_NUM     (CH_NUM),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .TO_CYCLES  (TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .avs_address    (avs_address),
    .avs_write      (avs_write),
    .avs_write_data (avs_write_data),
    .avs_read       (avs_read),
    .avs_read_data  (avs_read_data),
    .irq            (irq),
    .tmc_start      (tmc_start),
    .tmc_ch         (tmc_ch),
    .tmc_mosi_data  (tmc_mosi_data),
    .tmc_done       (tmc_done),
    .tmc_miso_data  (tmc_miso_data)
  );

  typedef struct {
    logic [3:0]    ch;
    logic [DW-1:0] data;
  } cmd_t;

  typedef struct {
    logic [3:0]    ch;
    logic [DW-1:0] data;
    logic [DW-1:0] reply;
  } vec_t;

  cmd_t sb[$];
  cmd_t e;
  vec_t vt[4];

  int n_cmp = 0;
  int n_err = 0;
  int n_start = 0;
  int n_done = 0;
  int cyc = 0;
  int last_start_cyc = 0;
  int prev_start_cyc = 0;
  int ecnt = 0;
  int lat = 10;
  bit stall = 1'b0;
  bit inj_done = 1'b0;
  bit eng_busy = 1'b0;
  logic [DW-1:0] reply = '0;

  int s0;
  int d0;
  logic [31:0] d;
  logic [DW-1:0] tmp;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // SPI engine model: scoreboards each launch, replies after lat cycles.
  always @(negedge clk) begin
    cyc++;
    tmc_done = inj_done;
    if (inj_done) tmc_miso_data = reply;
    if (!rst_n) begin
      eng_busy = 1'b0;
    end else if (tmc_start) begin
      n_start++;
      prev_start_cyc = last_start_cyc;
      last_start_cyc = cyc;
      if (sb.size() == 0) begin
        check("start_unexpected", 64'(n_start), 64'(0));
      end else begin
        e = sb.pop_front();
        check("start_ch", 64'(tmc_ch), 64'(e.ch));
        check("start_data", 64'(tmc_mosi_data), 64'(e.data));
      end
      eng_busy = 1'b1;
      ecnt = 0;
    end else if (eng_busy && !stall) begin
      ecnt++;
      if (ecnt >= lat) begin
        tmc_done = 1'b1;
        tmc_miso_data = reply;
        eng_busy = 1'b0;
        n_done++;
      end
    end
  end

  task automatic wr(input logic [7:0] a, input logic [31:0] v);
    @(posedge clk); #1;
    avs_address = a;
    avs_write_data = v;
    avs_write = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] v);
    @(posedge clk); #1;
    avs_address = a;
    avs_read = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0;
    @(negedge clk);
    v = avs_read_data;
  endtask

  task automatic cmd(input logic [3:0] ch, input logic [DW-1:0] data,
                     input bit expect_push);
    cmd_t c;
    c.ch = ch;
    c.data = data;
    wr(ADDR_MOSI_HI, 32'(data[DW-1:32]));
    wr(ADDR_MOSI_LO, data[31:0]);
    if (expect_push) sb.push_back(c);
    wr(ADDR_CMD, 32'(ch));
  endtask

  task automatic wait_starts(input int target, input int budget,
                             input string name);
    int i;
    i = 0;
    while (n_start < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, 64'(n_start), 64'(target));
  endtask

  task automatic wait_dones(input int target, input int budget,
                            input string name);
    int i;
    i = 0;
    while (n_done < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, 64'(n_done), 64'(target));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{4'd2, 40'hEC000100C3, 40'h123456789A};
    vt[1] = '{4'd0, 40'h01FFFFFFFF, 40'hFF00000001};
    vt[2] = '{4'd3, 40'h8000000000, 40'h00CAFEF00D};
    vt[3] = '{4'd1, 40'h5500AA00AA, 40'hA5DEADBEEF};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_irq", 64'(irq), 64'(0));
    check("rst_start", 64'(tmc_start), 64'(0));
    check("rst_ch", 64'(tmc_ch), 64'(0));
    check("rst_mosi", 64'(tmc_mosi_data), 64'(0));
    check("rst_rdata", 64'(avs_read_data), 64'(0));
    rd(ADDR_STATUS, d);
    check("rst_status", 64'(d), 64'h2);

    // done while idle must be ignored
    reply = '1;
    @(posedge clk); #1 inj_done = 1'b1;
    @(posedge clk); #1 inj_done = 1'b0;
    repeat (2) @(negedge clk);
    for (int c = 0; c < CH_NUM; c++) begin
      rd(8'(8'h10 + 2 * c), d);
      check("idle_done_miso_hi", 64'(d), 64'(0));
      rd(8'(8'h11 + 2 * c), d);
      check("idle_done_miso_lo", 64'(d), 64'(0));
    end
    rd(ADDR_STATUS, d);
    check("idle_done_status", 64'(d), 64'h2);

    // staging readback, HI truncated to DATA_W-32 bits
    wr(ADDR_MOSI_HI, 32'h000001FF);
    rd(ADDR_MOSI_HI, d);
    check("stg_hi_trunc", 64'(d), 64'hFF);
    wr(ADDR_MOSI_LO, 32'hDEADBEEF);
    rd(ADDR_MOSI_LO, d);
    check("stg_lo", 64'(d), 64'hDEADBEEF);
    rd(8'h30, d);
    check("unmapped_rd", 64'(d), 64'(0));

    for (int i = 0; i < 4; i++) begin
      s0 = n_start;
      d0 = n_done;
      reply = vt[i].reply;
      cmd(vt[i].ch, vt[i].data, 1'b1);
      wait_dones(d0 + 1, 100, "vec_done");
      check("vec_one_start", 64'(n_start - s0), 64'(1));
      rd(8'(8'h10 + 2 * vt[i].ch), d);
      check("vec_miso_hi", 64'(d), 64'(vt[i].reply[DW-1:32]));
      rd(8'(8'h11 + 2 * vt[i].ch), d);
      check("vec_miso_lo", 64'(d), 64'(vt[i].reply[31:0]));
      rd(ADDR_STATUS, d);
      check("vec_status", 64'(d), 64'h0A);
      wr(ADDR_STATUS, 32'h08);
    end
    rd(ADDR_STATUS, d);
    check("done_w1c", 64'(d), 64'h2);

    // overflow: one transfer in flight, then 9 pushes into 8 slots
    stall = 1'b1;
    s0 = n_start;
    d0 = n_done;
    reply = 40'h0102030405;
    cmd(4'd0, 40'hA000000000, 1'b1);
    wait_starts(s0 + 1, 50, "ovf_blocker_start");
    for (int i = 0; i < 9; i++) begin
      tmp = {8'(i + 1), 32'(i) * 32'h11111111};
      cmd(4'(i % 4), tmp, i < 8);
    end
    rd(ADDR_STATUS, d);
    check("ovf_level", 64'(d[15:8]), 64'(8));
    check("ovf_flags", 64'(d[7:0]), 64'h15);
    stall = 1'b0;
    wait_starts(s0 + 9, 600, "ovf_starts");
    wait_dones(d0 + 9, 100, "ovf_dones");
    check("ovf_sb_drained", 64'(sb.size()), 64'(0));
    rd(ADDR_STATUS, d);
    check("ovf_after", 64'(d), 64'h1A);
    wr(ADDR_STATUS, 32'h78);

    // bad channel
    s0 = n_start;
    wr(ADDR_CMD, 32'd5);
    repeat (5) @(negedge clk);
    check("cherr_nostart", 64'(n_start), 64'(s0));
    rd(ADDR_STATUS, d);
    check("cherr_status", 64'(d), 64'h22);
    wr(ADDR_IRQ_EN, 32'h20);
    repeat (2) @(negedge clk);
    check("cherr_irq_set", 64'(irq), 64'(1));
    rd(ADDR_IRQ_EN, d);
    check("irq_en_rd", 64'(d), 64'h20);
    wr(ADDR_STATUS, 32'h20);
    repeat (2) @(negedge clk);
    check("cherr_irq_clr", 64'(irq), 64'(0));
    rd(ADDR_STATUS, d);
    check("cherr_cleared", 64'(d), 64'h2);

    // reset during WAIT with 3 queued entries
    stall = 1'b1;
    s0 = n_start;
    for (int i = 0; i < 4; i++) begin
      tmp = {8'h3C, 32'(i + 1) * 32'h01010101};
      cmd(4'(i), tmp, 1'b1);
    end
    wait_starts(s0 + 1, 50, "rst_blocker_start");
    rd(ADDR_STATUS, d);
    check("rst_pre_level", 64'(d[15:8]), 64'(3));
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("rstw_start", 64'(tmc_start), 64'(0));
    check("rstw_ch", 64'(tmc_ch), 64'(0));
    check("rstw_mosi", 64'(tmc_mosi_data), 64'(0));
    check("rstw_irq", 64'(irq), 64'(0));
    check("rstw_rdata", 64'(avs_read_data), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    sb.delete();
    stall = 1'b0;
    s0 = n_start;
    d0 = n_done;
    repeat (20) @(negedge clk);
    check("rst_nostart", 64'(n_start), 64'(s0));
    rd(ADDR_STATUS, d);
    check("rst_status_empty", 64'(d), 64'h2);
    reply = 40'h77_01234567;
    cmd(4'd3, 40'h5AA5A5A5A5, 1'b1);
    wait_starts(s0 + 1, 50, "rst_new_start");
    wait_dones(d0 + 1, 50, "rst_new_done");
    rd(8'h17, d);
    check("rst_new_miso_lo", 64'(d), 64'h01234567);

`ifdef TMC_TIMEOUT_EN
    wr(ADDR_STATUS, 32'h78);
    stall = 1'b1;
    s0 = n_start;
    cmd(4'd1, 40'h1100000011, 1'b1);
    cmd(4'd2, 40'h2200000022, 1'b1);
    wait_starts(s0 + 2, 300, "to_second_start");
    check("to_gap", 64'(last_start_cyc - prev_start_cyc), 64'(102));
    rd(ADDR_STATUS, d);
    check("to_sticky", 64'(d[6]), 64'(1));
    stall = 1'b0;
    repeat (20) @(negedge clk);
`else
    wr(ADDR_STATUS, 32'h78);
    rd(ADDR_STATUS, d);
    check("no_to_bit6", 64'(d), 64'h2);
`endif

    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
